// File: rtl/serial_adder_ctrl.sv
// Serial adder sequencer: drives an external combinational 2-bit adder slice
// two bits per clock. Optional subtract mode is enabled with `define SADD_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sl_a1,
  output logic             sl_a0,
  output logic             sl_b1,
  output logic             sl_b0,
  output logic             sl_c0,
  input  logic             sl_c2,
  input  logic             sl_s1,
  input  logic             sl_s0
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             cr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH+1:0] acc_ext;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             run;
  logic             last;

`ifdef SADD_SUB_EN
  // Two's-complement subtract: a + ~b + 1; cout=1 then means no borrow.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // New slice sum bits enter at the top; the extended vector keeps WIDTH=2 legal.
  assign acc_ext  = {sl_s1, sl_s0, acc};
  assign acc_next = acc_ext[WIDTH+1:2];

  assign run  = (state == RUN);
  assign last = (cnt == CW'(HALF - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Slice inputs are forced low outside RUN so the slice sees quiet operands.
  assign sl_a1 = run & ra[1];
  assign sl_a0 = run & ra[0];
  assign sl_b1 = run & rb[1];
  assign sl_b0 = run & rb[0];
  assign sl_c0 = run & cr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      cr    <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b_load;
            cr    <= c_load;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cr  <= sl_c2;
          ra  <= ra >> 2;
          rb  <= rb >> 2;
          cnt <= cnt + 1'b1;
          if (last) begin
            // Result registers update only here, so they hold steady otherwise.
            sum   <= acc_next;
            cout  <= sl_c2;
            state <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8) with a
// behavioural 2-bit adder slice; define SADD_SUB_EN to cover subtract mode.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sl_a1, sl_a0, sl_b1, sl_b0, sl_c0;
  logic             sl_c2, sl_s1, sl_s0;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .sl_a1 (sl_a1),
    .sl_a0 (sl_a0),
    .sl_b1 (sl_b1),
    .sl_b0 (sl_b0),
    .sl_c0 (sl_c0),
    .sl_c2 (sl_c2),
    .sl_s1 (sl_s1),
    .sl_s0 (sl_s0)
  );

  // 2-bit adder slice: {c2,s1,s0} = {a1,a0} + {b1,b0} + c0
  assign {sl_c2, sl_s1, sl_s0} = {1'b0, sl_a1, sl_a0} + {1'b0, sl_b1, sl_b0} + {2'b00, sl_c0};

  initial clk = 1'b0;
  always #100 clk = ~clk;

  // Launches one operation and watches it to completion. n counts negedges
  // after the accepting edge: RUN occupies n=0..3, DONE is n=4.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                       output logic [WIDTH-1:0] rs, output logic rc,
                       output int nbusy, output int ndone, output int done_at, output logic early);
    logic [WIDTH-1:0] sum0;
    logic             cout0;
    @(negedge clk);
    sum0 = sum; cout0 = cout;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0; done_at = -1; early = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!busy) break;
      nbusy++;
      if (done) begin ndone++; done_at = n; end
      if (!done && (sum !== sum0 || cout !== cout0)) early = 1'b1;
      @(negedge clk);
    end
    rs = sum; rc = cout;
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    checks++;
    if ({sl_a1, sl_a0, sl_b1, sl_b0, sl_c0} !== 5'b0) begin
      errors++; $display("FAIL reset_slice got %b exp 00000", {sl_a1, sl_a0, sl_b1, sl_b0, sl_c0});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] rs; logic rc; int nb, nd, da; logic early;
    do_op(8'h5A, 8'h3C, 1'b0, rs, rc, nb, nd, da, early);
    checks++; if (nb != 5) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 5", nb); end
    checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", nd); end
    checks++; if (da != 4) begin errors++; $display("FAIL basic_done_latency got %0d exp 4", da); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_sum_changed_early got %b exp 0", early); end
    checks++; if (rs !== 8'h96) begin errors++; $display("FAIL basic_sum got %h exp 96", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL basic_cout got %b exp 0", rc); end
    @(negedge clk);
    checks++; if (sum !== 8'h96) begin errors++; $display("FAIL basic_sum_hold got %h exp 96", sum); end
  endtask

  task automatic test_carry();
    logic [WIDTH-1:0] rs; logic rc; int nb, nd, da; logic early;
    do_op(8'hFF, 8'h01, 1'b0, rs, rc, nb, nd, da, early);
    checks++; if (rs !== 8'h00) begin errors++; $display("FAIL ripple_sum got %h exp 00", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL ripple_cout got %b exp 1", rc); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL ripple_sum_changed_early got %b exp 0", early); end
    do_op(8'h00, 8'h00, 1'b1, rs, rc, nb, nd, da, early);
    checks++; if (rs !== 8'h01) begin errors++; $display("FAIL cin_zero_sum got %h exp 01", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL cin_zero_cout got %b exp 0", rc); end
    do_op(8'hFF, 8'hFF, 1'b1, rs, rc, nb, nd, da, early);
    checks++; if (rs !== 8'hFF) begin errors++; $display("FAIL cin_max_sum got %h exp ff", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL cin_max_cout got %b exp 1", rc); end
  endtask

  task automatic test_start_while_busy();
    int nd = 0;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (done) nd++;
      @(negedge clk);
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", nd); end
    checks++; if (sum !== 8'h33) begin errors++; $display("FAIL ignore_sum got %h exp 33", sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic seen;
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1;
    if (done) seen = 1'b1; else wait_done(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b exp 1", seen); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL b2b_first_sum got %h exp 00", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_first_cout got %b exp 1", cout); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b exp 1", busy); end
    start = 1'b0;
    wait_done(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", seen); end
    checks++; if (sum !== 8'h47) begin errors++; $display("FAIL b2b_second_sum got %h exp 47", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_second_cout got %b exp 0", cout); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int nd = 0;
    logic [WIDTH-1:0] rs; logic rc; int nb, nd2, da; logic early;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #10 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum got %h exp 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL abort_cout got %b exp 0", cout); end
    checks++;
    if ({sl_a1, sl_a0, sl_b1, sl_b0, sl_c0} !== 5'b0) begin
      errors++; $display("FAIL abort_slice got %b exp 00000", {sl_a1, sl_a0, sl_b1, sl_b0, sl_c0});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", nd); end
    do_op(8'h01, 8'h01, 1'b0, rs, rc, nb, nd2, da, early);
    checks++; if (rs !== 8'h02) begin errors++; $display("FAIL abort_next_sum got %h exp 02", rs); end
    checks++; if (nd2 != 1) begin errors++; $display("FAIL abort_next_done got %0d exp 1", nd2); end
  endtask

`ifdef SADD_SUB_EN
  task automatic test_sub();
    logic [WIDTH-1:0] rs; logic rc; int nb, nd, da; logic early;
    sub = 1'b1;
    do_op(8'h10, 8'h01, 1'b0, rs, rc, nb, nd, da, early);
    checks++; if (rs !== 8'h0F) begin errors++; $display("FAIL sub_nb_sum got %h exp 0f", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub_nb_cout got %b exp 1", rc); end
    do_op(8'h01, 8'h02, 1'b0, rs, rc, nb, nd, da, early);
    checks++; if (rs !== 8'hFF) begin errors++; $display("FAIL sub_borrow_sum got %h exp ff", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got %b exp 0", rc); end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
`ifdef SADD_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
